// File: rtl/int_controller_if.sv
// Signal bundle between the instruction decoder and the two-source interrupt controller.
// The master modport drives requests and configuration; the slave modport returns entry/vector/ack status.
interface int_controller_if;
  logic        i_irq_a;
  logic        i_irq_b;
  logic [5:0]  i_ct_control_code;
  logic [15:0] i_data;
  logic        i_inst_boundary;
  logic        i_lock;
  logic        i_iret;
  logic        o_interrupt;
  logic        o_pc_set;
  logic [15:0] o_addr;
  logic        o_ack_a;
  logic        o_ack_b;
  logic        o_busy;

  modport master (
    output i_irq_a, i_irq_b, i_ct_control_code, i_data,
    output i_inst_boundary, i_lock, i_iret,
    input  o_interrupt, o_pc_set, o_addr, o_ack_a, o_ack_b, o_busy
  );

  modport slave (
    input  i_irq_a, i_irq_b, i_ct_control_code, i_data,
    input  i_inst_boundary, i_lock, i_iret,
    output o_interrupt, o_pc_set, o_addr, o_ack_a, o_ack_b, o_busy
  );
endinterface

// File: rtl/int_controller.sv
// Two-source interrupt controller for MACPU: edge-latched requests, programmable priority,
// instruction-boundary gated entry, and a single non-nesting handler level.
module int_controller #(
  parameter logic [15:0] VEC_A_DEFAULT = 16'h0010,
  parameter logic [15:0] VEC_B_DEFAULT = 16'h0020
) (
  input  logic            clk,
  input  logic            n_rst,
  int_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BND,
    ST_INT_PULSE,
    ST_VECTOR,
    ST_SERVICE
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        en_a_q, en_b_q, prio_q;
  logic [15:0] vec_a_q, vec_b_q;
  logic [1:0]  irq_q, pend_q, pend_d;
  logic [1:0]  irq_now, en_now, rise, clr;
  logic        cfg_strobe;
  logic [1:0]  vec_op;
  logic        winner_b;
  logic        int_pulse, pc_set, ack_a, ack_b, busy;
  logic [15:0] addr;

  assign irq_now    = {bus.i_irq_b, bus.i_irq_a};
  assign en_now     = {en_b_q, en_a_q};
  assign cfg_strobe = bus.i_ct_control_code[3];
  assign vec_op     = bus.i_ct_control_code[5:4];
  // B wins when it is the only request, or when both are pending and B has priority.
  assign winner_b   = pend_q[1] & (~pend_q[0] | prio_q);

  // Index 0 is source A, index 1 is source B; a new edge outranks any clear.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign rise[gi]   = irq_now[gi] & ~irq_q[gi] & en_now[gi];
      assign clr[gi]    = ((state_q == ST_INT_PULSE) && (sel_q == 1'(gi)))
                        || (cfg_strobe && !bus.i_ct_control_code[gi]);
      assign pend_d[gi] = rise[gi] | (pend_q[gi] & ~clr[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      irq_q   <= 2'b00;
      pend_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      irq_q   <= irq_now;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      en_a_q  <= 1'b0;
      en_b_q  <= 1'b0;
      prio_q  <= 1'b0;
      vec_a_q <= VEC_A_DEFAULT;
      vec_b_q <= VEC_B_DEFAULT;
    end else begin
      if (cfg_strobe) begin
        en_a_q <= bus.i_ct_control_code[0];
        en_b_q <= bus.i_ct_control_code[1];
        prio_q <= bus.i_ct_control_code[2];
      end
      case (vec_op)
        2'd1: vec_a_q <= bus.i_data;
        2'd2: vec_b_q <= bus.i_data;
        2'd3: begin
          vec_a_q <= VEC_A_DEFAULT;
          vec_b_q <= VEC_B_DEFAULT;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    int_pulse = 1'b0;
    pc_set    = 1'b0;
    addr      = 16'h0000;
    ack_a     = 1'b0;
    ack_b     = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pend_q) state_d = ST_WAIT_BND;
      end
      ST_WAIT_BND: begin
        if (~|pend_q) begin
          state_d = ST_IDLE;
        end else if (bus.i_inst_boundary && !bus.i_lock) begin
          sel_d   = winner_b;
          state_d = ST_INT_PULSE;
        end
      end
      ST_INT_PULSE: begin
        int_pulse = 1'b1;
        ack_a     = ~sel_q;
        ack_b     = sel_q;
        state_d   = ST_VECTOR;
      end
      ST_VECTOR: begin
        pc_set  = 1'b1;
        addr    = sel_q ? vec_b_q : vec_a_q;
        state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        busy = 1'b1;
        if (bus.i_iret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_interrupt = int_pulse;
  assign bus.o_pc_set    = pc_set;
  assign bus.o_addr      = addr;
  assign bus.o_ack_a     = ack_a;
  assign bus.o_ack_b     = ack_b;
  assign bus.o_busy      = busy;

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed scenarios plus random traffic, all checked each cycle
// against a timeline-based reference model, with literal expectations pinning key results.
module tb_int_controller;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  int_controller_if bus();

  int_controller #(
    .VEC_A_DEFAULT(16'h0010),
    .VEC_B_DEFAULT(16'h0020)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_t counts cycles since the grant decision (-1 = no handler).
  // 1 -> interrupt/ack cycle, 2 -> vector load cycle, >=3 -> handler running until iret.
  logic [1:0]  m_en = 2'b00, m_pend = 2'b00, m_prev = 2'b00;
  logic        m_prio = 1'b0;
  logic [15:0] m_vec [2] = '{16'h0010, 16'h0020};
  int          m_t = -1;
  bit          m_seek = 1'b0;
  int          m_sel = 0;

  always @(posedge clk or negedge n_rst) begin
    logic [1:0] irq, rise, clr;
    logic [5:0] ct;
    bit         any;
    if (!n_rst) begin
      m_en = 2'b00; m_pend = 2'b00; m_prev = 2'b00; m_prio = 1'b0;
      m_vec[0] = 16'h0010; m_vec[1] = 16'h0020;
      m_t = -1; m_seek = 1'b0; m_sel = 0;
    end else begin
      irq  = {bus.i_irq_b, bus.i_irq_a};
      ct   = bus.i_ct_control_code;
      rise = irq & ~m_prev & m_en;
      any  = |m_pend;
      clr  = 2'b00;
      if (m_t < 0) begin
        if (!m_seek) m_seek = any;
        else if (!any) m_seek = 1'b0;
        else if (bus.i_inst_boundary && !bus.i_lock) begin
          if (m_pend == 2'b11) m_sel = m_prio ? 1 : 0;
          else m_sel = m_pend[1] ? 1 : 0;
          m_t = 1;
          m_seek = 1'b0;
        end
      end else if (m_t == 1) begin
        clr[m_sel] = 1'b1;
        m_t = 2;
      end else if (m_t == 2) begin
        m_t = 3;
      end else if (bus.i_iret) begin
        m_t = -1;
      end
      if (ct[3]) clr = clr | ~ct[1:0];
      m_pend = rise | (m_pend & ~clr);
      if (ct[3]) begin
        m_en = ct[1:0];
        m_prio = ct[2];
      end
      case (ct[5:4])
        2'd1: m_vec[0] = bus.i_data;
        2'd2: m_vec[1] = bus.i_data;
        2'd3: begin m_vec[0] = 16'h0010; m_vec[1] = 16'h0020; end
        default: ;
      endcase
      m_prev = irq;
    end
  end

  always @(negedge clk) begin
    check("interrupt", bus.o_interrupt, m_t == 1);
    check("ack_a", bus.o_ack_a, (m_t == 1) && (m_sel == 0));
    check("ack_b", bus.o_ack_b, (m_t == 1) && (m_sel == 1));
    check("pc_set", bus.o_pc_set, m_t == 2);
    check("addr", bus.o_addr, (m_t == 2) ? m_vec[m_sel] : 16'h0000);
    check("busy", bus.o_busy, m_t >= 3);
    if (bus.o_pc_set) $display("txn vector load addr=%h ack_src=%0d", bus.o_addr, m_sel);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.i_ct_control_code = 6'd0;
    bus.i_iret = 1'b0;
  endtask

  task automatic wait_pc(input logic [15:0] exp, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.o_pc_set) begin
        found = 1'b1;
        check(name, bus.o_addr, exp);
      end
      cyc();
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=no_pc_set required=pc_set", name);
    end
  endtask

  task automatic expect_busy(input string name);
    @(negedge clk);
    check(name, bus.o_busy, 1'b1);
    cyc();
  endtask

  task automatic pulse_irq(input bit a, input bit b);
    bus.i_irq_a = a; bus.i_irq_b = b;
    cyc();
    bus.i_irq_a = 1'b0; bus.i_irq_b = 1'b0;
  endtask

  task automatic iret();
    bus.i_iret = 1'b1;
    cyc();
  endtask

  initial begin
    bus.i_irq_a = 0; bus.i_irq_b = 0; bus.i_ct_control_code = 0; bus.i_data = 0;
    bus.i_inst_boundary = 0; bus.i_lock = 0; bus.i_iret = 0;
    repeat (2) cyc();
    @(negedge clk);
    check("reset interrupt", bus.o_interrupt, 1'b0);
    check("reset busy", bus.o_busy, 1'b0);
    n_rst = 1'b1;
    cyc();

    // Loaded vector A, single request.
    bus.i_ct_control_code = 6'b011001; bus.i_data = 16'h0100;
    cyc();
    bus.i_inst_boundary = 1'b1;
    pulse_irq(1, 0);
    wait_pc(16'h0100, "t1 vec A loaded");
    expect_busy("t1 busy");
    iret();

    // Simultaneous requests, A priority, defaults restored.
    bus.i_ct_control_code = 6'b111011;
    cyc();
    pulse_irq(1, 1);
    wait_pc(16'h0010, "t2 A first");
    expect_busy("t2 busy");
    iret();
    wait_pc(16'h0020, "t2 B after iret");
    iret();

    // Simultaneous requests, B priority.
    bus.i_ct_control_code = 6'b001111;
    cyc();
    pulse_irq(1, 1);
    wait_pc(16'h0020, "t3 B first");
    iret();
    wait_pc(16'h0010, "t3 A after iret");
    iret();

    // Boundary low, then lock, then release.
    bus.i_ct_control_code = 6'b001001;
    bus.i_inst_boundary = 1'b0;
    cyc();
    pulse_irq(1, 0);
    repeat (5) begin @(negedge clk); check("t4 no bnd", bus.o_interrupt, 1'b0); cyc(); end
    bus.i_lock = 1'b1; bus.i_inst_boundary = 1'b1;
    repeat (3) begin @(negedge clk); check("t4 locked", bus.o_interrupt, 1'b0); cyc(); end
    bus.i_lock = 1'b0;
    cyc();
    @(negedge clk);
    check("t4 after unlock", bus.o_interrupt, 1'b1);
    cyc();
    wait_pc(16'h0010, "t4 vec");
    iret();

    // Disable while waiting, edge while disabled never serviced.
    bus.i_inst_boundary = 1'b0;
    pulse_irq(1, 0);
    cyc(); cyc();
    bus.i_ct_control_code = 6'b001000;
    cyc();
    pulse_irq(1, 0);
    cyc();
    bus.i_ct_control_code = 6'b001001; bus.i_inst_boundary = 1'b1;
    cyc();
    repeat (6) begin @(negedge clk); check("t5 dropped", bus.o_interrupt, 1'b0); cyc(); end

    // Reset mid-handler with B pending.
    bus.i_ct_control_code = 6'b011011; bus.i_data = 16'h1234;
    cyc();
    pulse_irq(1, 1);
    wait_pc(16'h1234, "t6 loaded A");
    n_rst = 1'b0;
    #1;
    check("t6 busy async reset", bus.o_busy, 1'b0);
    cyc();
    n_rst = 1'b1;
    iret();
    repeat (4) begin
      @(negedge clk);
      check("t6 idle busy", bus.o_busy, 1'b0);
      check("t6 idle int", bus.o_interrupt, 1'b0);
      cyc();
    end
    bus.i_ct_control_code = 6'b001001;
    cyc();
    pulse_irq(1, 0);
    wait_pc(16'h0010, "t6 default A");
    iret();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.i_irq_a = ($urandom_range(0, 3) == 0);
      bus.i_irq_b = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) bus.i_ct_control_code = 6'($urandom_range(0, 63));
      bus.i_data = 16'($urandom);
      bus.i_inst_boundary = ($urandom_range(0, 9) < 7);
      bus.i_lock = ($urandom_range(0, 4) == 0);
      bus.i_iret = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 599) == 0) n_rst = 1'b0;
      else n_rst = 1'b1;
      @(posedge clk);
      #1;
    end
    n_rst = 1'b1;
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Two-source interrupt controller for the 16-bit MACPU core.
- Latches requests from sources A and B and arbitrates them by programmable priority. Configuration comes from the decoder's 6-bit controller control code.
- Raises the decoder's interrupt input only at instruction boundaries, then loads the winning vector into the program counter.
- Holds off further interrupts until the handler signals return (no nesting).

Parameters:
VEC_A_DEFAULT, 16'h0010, reset/restore value of vector A
VEC_B_DEFAULT, 16'h0020, reset/restore value of vector B

Ports:
clk  input  1  system clock, all state on rising edge
n_rst  input  1  asynchronous active-low reset
i_irq_a  input  1  interrupt request A, rising-edge sensitive
i_irq_b  input  1  interrupt request B, rising-edge sensitive
i_ct_control_code  input  6  decoder controller code: [0] en A, [1] en B, [2] prio (0 A>B, 1 B>A), [3] set-info strobe, [5:4] vector op (0 none, 1 load A, 2 load B, 3 restore defaults)
i_data  input  16  vector value for [5:4]=1/2
i_inst_boundary  input  1  decoder is in INST fetch state
i_lock  input  1  bus lock; blocks interrupt entry
i_iret  input  1  one-cycle return-from-interrupt pulse
o_interrupt  output  1  one-cycle interrupt pulse to decoder
o_pc_set  output  1  PC load enable, one cycle
o_addr  output  16  vector address; 0 when o_pc_set=0
o_ack_a  output  1  one-cycle grant pulse for A
o_ack_b  output  1  one-cycle grant pulse for B
o_busy  output  1  handler in progress

Behaviour:
- Reset (async, n_rst=0): state IDLE; en_a=en_b=prio=0; vec_a=VEC_A_DEFAULT; vec_b=VEC_B_DEFAULT; pend_a=pend_b=0; edge-detect registers=0; all outputs 0.
- Edge detect: irq_x_d is the registered copy of i_irq_x.
  - pend_x is set at the clock where i_irq_x & ~irq_x_d & en_x.
  - Requests arriving while disabled are dropped.
  - Set wins over clear in the same cycle.
- Config: when [3]=1, en_a/en_b/prio load from [2:0] at the clock edge. When [3]=0 they hold.
  - Disabling a source also clears its pend bit.
- Vector op: applied independently of [3] on every cycle it is nonzero.
  - 3 restores both defaults.
  - A write in the same cycle as VECTOR state does not affect o_addr in that cycle (registered value is used).
- FSM (Moore outputs):
  - IDLE: if (pend_a|pend_b) go to WAIT_BND.
  - WAIT_BND: if no pend, go to IDLE. Else if i_inst_boundary & ~i_lock, latch winner into sel and go to INT_PULSE. Else stay.
    - Winner: the only pending source; if both pending, A when prio=0, else B.
  - INT_PULSE: o_interrupt=1; o_ack_sel=1; pend_sel cleared; go to VECTOR.
  - VECTOR: o_pc_set=1; o_addr=vec_sel; go to SERVICE.
  - SERVICE: o_busy=1. On i_iret go to IDLE.
    - New edges still set pend during SERVICE and are serviced after return.
    - Config changes affect the next arbitration only.
- i_iret in any state other than SERVICE is ignored.
- Latency: edge sampled at edge k (pend=1 after k).
  - IDLE→WAIT_BND at k+1.
  - With boundary already high, o_interrupt is high in the cycle after k+2, o_pc_set after k+3, o_busy from k+4.
- The losing pending source remains pending. It is granted after i_iret via IDLE→WAIT_BND (min 2 cycles after iret).
- Reset mid-handler: everything returns to reset values immediately; pending requests are lost.

Test Plan:
- Reset → all outputs 0. Load A via [5:4]=1, i_data=16'h0100 and enable A with ct=6'b011001. Pulse i_irq_a, boundary=1 → o_interrupt 1 cycle, o_ack_a, then o_pc_set with o_addr=16'h0100, then o_busy=1.
- Both enabled, prio=0. i_irq_a and i_irq_b rise in the same cycle → A granted (o_addr=16'h0010). After i_iret, B granted (o_addr=16'h0020) without a new edge.
- Same as above with prio=1 → B granted first, then A.
- A enabled, pend_a set. Hold i_inst_boundary=0 for 5 cycles, then i_lock=1 with boundary=1 → no o_interrupt. Drop i_lock → o_interrupt next cycle.
- Disable A (ct [3]=1, [0]=0) while in WAIT_BND → FSM returns to IDLE, no pulse. An i_irq_a edge while disabled is never serviced after re-enable.
- Assert n_rst=0 during SERVICE with pend_b=1 → o_busy=0 and pend cleared immediately; vectors return to defaults. i_iret pulse in IDLE → no effect.
